// File: rtl/md_if.sv
// Operation-issue and HI/LO result bundle between decode/execute and md_unit.
interface md_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs, rt, input busy, done, hi, lo);
    modport slave  (input start, op, rs, rt, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy/done handshake.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate operations.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [3:0]  op_reg, op_next;
    logic [31:0] rs_reg, rs_next;
    logic [31:0] rt_reg, rt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    // Datapath works only on latched operands so the inputs may change freely while busy.
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] num, den, den_safe, uq, ur, quo, rem;

    always_comb begin
        prod_s     = {{32{rs_reg[31]}}, rs_reg} * {{32{rt_reg[31]}}, rt_reg};
        prod_u     = {32'd0, rs_reg} * {32'd0, rt_reg};
        div_signed = (op_reg == OP_DIV);
        num        = (div_signed && rs_reg[31]) ? -rs_reg : rs_reg;
        den        = (div_signed && rt_reg[31]) ? -rt_reg : rt_reg;
        den_safe   = (den == 32'd0) ? 32'd1 : den;
        uq         = num / den_safe;
        ur         = num % den_safe;
        // Magnitude division then sign fix-up: truncation toward zero, remainder follows dividend.
        quo        = (div_signed && (rs_reg[31] ^ rt_reg[31])) ? -uq : uq;
        rem        = (div_signed && rs_reg[31]) ? -ur : ur;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        rs_next    = rs_reg;
        rt_next    = rt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU
`ifdef MD_MADD_EN
                        , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                        : begin
                            state_next = RUN;
                            cnt_next   = 8'(MULT_CYCLES);
                            op_next    = bus.op;
                            rs_next    = bus.rs;
                            rt_next    = bus.rt;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_next = RUN;
                            cnt_next   = 8'(DIV_CYCLES);
                            op_next    = bus.op;
                            rs_next    = bus.rs;
                            rt_next    = bus.rt;
                        end
                        OP_MTHI: hi_next = bus.rs;
                        OP_MTLO: lo_next = bus.rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg == 8'd1) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    case (op_reg)
                        OP_MULT:  {hi_next, lo_next} = prod_s;
                        OP_MULTU: {hi_next, lo_next} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (rt_reg != 32'd0) begin
                                hi_next = rem;
                                lo_next = quo;
                            end
                        end
`ifdef MD_MADD_EN
                        OP_MADD:  {hi_next, lo_next} = {hi_reg, lo_reg} + prod_s;
                        OP_MADDU: {hi_next, lo_next} = {hi_reg, lo_reg} + prod_u;
                        OP_MSUB:  {hi_next, lo_next} = {hi_reg, lo_reg} - prod_s;
                        OP_MSUBU: {hi_next, lo_next} = {hi_reg, lo_reg} - prod_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            op_reg    <= 4'd0;
            rs_reg    <= 32'd0;
            rt_reg    <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus randomized back-to-back traffic.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MADD  = 4'd7;
    localparam logic [3:0] MADDU = 4'd8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_if bus ();
    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference: architectural result of one long op from the HI/LO value at commit.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint sa = $signed(a);
        longint sb = $signed(b);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        longint q;
        longint r;
        case (op)
            1: return sa * sb;
            2: return ua * ub;
            3: begin
                if (b == 32'd0) return hl;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (b == 32'd0) return hl;
                return {a % b, a / b};
            end
            7:  return hl + sa * sb;
            8:  return hl + ua * ub;
            9:  return hl - sa * sb;
            10: return hl - ua * ub;
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue a long op at the current negedge; optionally inject an MTLO start mid-flight.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int inject_at, input string name);
        logic [63:0] expv;
        int n;
        int cyc;
        bit bad;
        cyc  = (op == DIV || op == DIVU) ? DC : MC;
        expv = model(op, a, b, {m_hi, m_lo});
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        n = 0;
        bad = 1'b0;
        while (bus.busy === 1'b1 && n < 300) begin
            n++;
            if (bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) bad = 1'b1;
            if (n == inject_at) begin
                bus.start = 1'b1; bus.op = MTLO; bus.rs = 32'h1234;
            end else begin
                bus.start = 1'b0; bus.op = NONE;
            end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.op = NONE;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_in_flight: done/hi/lo changed while busy, required done=0 hi=%h lo=%h", name, m_hi, m_lo);
        end
        checks++;
        if (n !== cyc) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, n, cyc);
        end
        m_hi = expv[63:32];
        m_lo = expv[31:0];
        checks++;
        if (bus.done !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL %s_commit: got done=%b hi=%h lo=%h required done=1 hi=%h lo=%h",
                     name, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
        $display("txn %s op=%0d rs=%h rt=%h cycles=%0d hi=%h lo=%h", name, op, a, b, n, bus.hi, bus.lo);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input string name);
        bus.start = 1'b1; bus.op = op; bus.rs = a;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        if (op == MTHI) m_hi = a; else m_lo = a;
        checks++;
        if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                     name, bus.hi, bus.lo, bus.busy, bus.done, m_hi, m_lo);
        end
        $display("txn %s op=%0d rs=%h hi=%h lo=%h", name, op, a, bus.hi, bus.lo);
    endtask

    task automatic expect_ignored(input logic [3:0] op, input string name);
        bus.start = 1'b1; bus.op = op; bus.rs = $urandom; bus.rt = $urandom;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL %s: got busy=%b done=%b hi=%h lo=%h required busy=0 done=0 hi=%h lo=%h",
                     name, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
        $display("txn %s op=%0d ignored", name, op);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.op = MULT; bus.rs = 32'd3; bus.rt = 32'd4;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b0;
        bus.start = 1'b0; bus.op = NONE;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_dominates_start: got busy=%b required 0", bus.busy);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_long(MULT,  32'hFFFF_FFFF, 32'd2, 0, "mult");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_vector: got hi=%h lo=%h required ffffffff fffffffe", bus.hi, bus.lo);
        end
        run_long(MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu");
        checks++;
        if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_vector: got hi=%h lo=%h required 00000001 fffffffe", bus.hi, bus.lo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_single_pulse: got done=%b required 0", bus.done);
        end
    endtask

    task automatic test_div();
        run_long(DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_neg_vector: got hi=%h lo=%h required ffffffff fffffffd", bus.hi, bus.lo);
        end
        run_long(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            failures++;
            $display("FAIL div_ovf_vector: got hi=%h lo=%h required 00000000 80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero();
        do_mt(MTHI, 32'hA5A5_0001, "mthi_pre");
        do_mt(MTLO, 32'h5A5A_0002, "mtlo_pre");
        run_long(DIVU, 32'd7, 32'd0, 0, "divu_zero");
        run_long(DIV,  32'hFFFF_0000, 32'd0, 0, "div_zero");
    endtask

    task automatic test_busy_ignore();
        run_long(MULT, 32'd1000, 32'hFFFF_FFFD, 2, "mult_ignore_mtlo");
        run_long(DIVU, 32'd100,  32'd7,         4, "divu_ignore_mtlo");
    endtask

    task automatic test_mtlo();
        do_mt(MTLO, 32'h1234, "mtlo");
        do_mt(MTHI, $urandom, "mthi");
        expect_ignored(NONE, "op_none");
`ifndef MD_MADD_EN
        expect_ignored(MADD, "madd_disabled");
        expect_ignored(4'd10, "msubu_disabled");
`endif
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        do_mt(MTHI, 32'h1111_2222, "mthi_pre_rst");
        bus.start = 1'b1; bus.op = DIV; bus.rs = 32'd50; bus.rt = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        bad = 1'b0;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_discards_result: late done/busy/hi/lo activity, required none");
        end
        $display("txn reset_mid_run hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int i = 0; i < 30; i++) begin
`ifdef MD_MADD_EN
            op = 4'($urandom_range(1, 10));
`else
            op = 4'($urandom_range(1, 6));
`endif
            if (op == MTHI || op == MTLO) do_mt(op, rnd_operand(), "rand_mt");
            else run_long(op, rnd_operand(), rnd_operand(), 0, "rand_long");
        end
    endtask

`ifdef MD_MADD_EN
    task automatic test_madd();
        do_mt(MTHI, 32'd0, "mthi_acc");
        do_mt(MTLO, 32'hFFFF_FFFF, "mtlo_acc");
        run_long(MADDU, 32'd1, 32'd1, 0, "maddu_carry");
        checks++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL maddu_vector: got hi=%h lo=%h required 00000001 00000000", bus.hi, bus.lo);
        end
        for (int i = 0; i < 8; i++)
            run_long(4'($urandom_range(7, 10)), rnd_operand(), rnd_operand(), 0, "rand_acc");
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = NONE; bus.rs = 32'd0; bus.rt = 32'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_mtlo();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MD_MADD_EN
        test_madd();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
